tse_rx_controller: RTL and testbench

Receive-side counterpart of the TSE transmit controller. Sits on the Triple-Speed Ethernet MAC RX Avalon-ST source (32-bit, RX_SHIFT16 enabled) as an Avalon-ST sink. Parses each frame header and filters on destination MAC and EtherType. From accepted frames it extracts the speed-sensor and ADC fields, and presents them as registered outputs with a one-cycle valid strobe.

---
 rtl/AlteraAvalon_Pkg.sv | 18 +
 rtl/tse_rx_controller_pkg.sv | 22 ++
 rtl/tse_rx_stats_counter.sv | 21 ++
 rtl/tse_rx_controller.sv | 191 +++++++++++++++++++
 tb/tb_tse_rx_controller.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/AlteraAvalon_Pkg.sv
// Avalon-ST struct types shared by Altera/Intel streaming interfaces.
// from_source carries the data beat towards a sink; to_source returns backpressure.
package AlteraAvalon_Pkg;

    typedef struct packed {
        logic [31:0] Data;
        logic        Valid;
        logic        StartOfPacket;
        logic        EndOfPacket;
        logic [1:0]  Empty;
        logic        Error;
    } avalon_st_from_source_t;

    typedef struct packed {
        logic Ready;
    } avalon_st_to_source_t;

endpackage

// File: rtl/tse_rx_controller_pkg.sv
// Shared TSE receive definitions: default EtherType, beat-index constants,
// FSM state encoding and a saturating 16-bit increment helper.
package tse_rx_controller_pkg;

    localparam logic [15:0] TSE_ETHERTYPE_DEFAULT = 16'h88B5;

    // Beats 0..3 carry the MAC header (with the 16-bit shift pad); beat 4 carries the payload
    localparam logic [15:0] HDR_BEATS    = 16'd4;
    localparam logic [15:0] PAYLOAD_BEAT = 16'd4;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE    = 2'd0;
    localparam rx_state_t ST_HEADER  = 2'd1;
    localparam rx_state_t ST_PAYLOAD = 2'd2;
    localparam rx_state_t ST_DRAIN   = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/tse_rx_stats_counter.sv
// Saturating statistics counter: counts single-cycle increment requests and
// holds at all-ones instead of wrapping back to zero.
module tse_rx_stats_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count increment requests, sticking at the maximum value
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tse_rx_controller.sv
// TSE MAC receive controller (Avalon-ST sink, 32-bit, RX_SHIFT16 layout).
// Filters frames on destination MAC (local or broadcast) and EtherType, pulls the
// speed/ADC pair from payload beat 4, and publishes it when a good frame ends.
// Build option: define TSE_RX_STATS_EN to build the accepted/dropped frame
// counters; without it both counter ports are tied to zero.
module tse_rx_controller
    import AlteraAvalon_Pkg::*;
    import tse_rx_controller_pkg::*;
#(
    parameter int          SPEED_SENSOR_WIDTH   = 16,
    parameter int          ADC_WIDTH            = 16,
    parameter int          TSE_RX_ST_DATA_WIDTH = 32,
    parameter logic [47:0] LOCAL_MAC            = 48'h00_1C_23_17_4A_CB,
    parameter logic [15:0] ETHERTYPE            = TSE_ETHERTYPE_DEFAULT,
    parameter int          STATS_WIDTH          = 32
) (
    input  logic                          CLOCK,
    input  logic                          RESET_N,
    input  logic [15:0]                   MTU,
    input  avalon_st_from_source_t        AVALON_ST_SINK_IN_1,
    output avalon_st_to_source_t          AVALON_ST_SINK_OUT_1,
    output logic [SPEED_SENSOR_WIDTH-1:0] SPEED_SENSOR,
    output logic [ADC_WIDTH-1:0]          ADC,
    output logic                          DATA_VALID,
    output logic [STATS_WIDTH-1:0]        RX_FRAME_COUNT,
    output logic [STATS_WIDTH-1:0]        RX_DROP_COUNT
);

    localparam logic [15:0] MIN_FRAME_BEATS = PAYLOAD_BEAT + 16'd1;

    logic                            ready_q;
    rx_state_t                       state_q, state_d;
    logic [15:0]                     beat_cnt_q, beat_cnt_d;
    logic                            ucast_ok_q, ucast_ok_d;
    logic                            bcast_ok_q, bcast_ok_d;
    logic                            type_ok_q, type_ok_d;
    logic                            err_q, err_d;
    logic [SPEED_SENSOR_WIDTH-1:0]   speed_sh_q, speed_sh_d;
    logic [ADC_WIDTH-1:0]            adc_sh_q, adc_sh_d;

    logic [TSE_RX_ST_DATA_WIDTH-1:0] beat_data;
    logic                            beat_fire;
    logic                            sop_beat;
    logic                            eop_beat;
    logic                            in_frame;
    logic                            mid_beat;
    logic                            frame_end;
    logic                            frame_good;
    logic                            commit;
    logic                            unused_empty;

    assign beat_data    = AVALON_ST_SINK_IN_1.Data;
    assign beat_fire    = AVALON_ST_SINK_IN_1.Valid & ready_q;
    assign sop_beat     = beat_fire & AVALON_ST_SINK_IN_1.StartOfPacket;
    assign eop_beat     = beat_fire & AVALON_ST_SINK_IN_1.EndOfPacket;
    assign in_frame     = (state_q != ST_IDLE);
    assign mid_beat     = beat_fire & ~AVALON_ST_SINK_IN_1.StartOfPacket & in_frame;
    assign frame_end    = eop_beat & (sop_beat | in_frame);
    assign unused_empty = ^AVALON_ST_SINK_IN_1.Empty;

    assign AVALON_ST_SINK_OUT_1.Ready = ready_q;

    // Next-state and per-frame flag/shadow updates; a start-of-packet always restarts parsing at beat0
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        ucast_ok_d = ucast_ok_q;
        bcast_ok_d = bcast_ok_q;
        type_ok_d  = type_ok_q;
        err_d      = err_q;
        speed_sh_d = speed_sh_q;
        adc_sh_d   = adc_sh_q;

        if (sop_beat) begin
            state_d    = ST_HEADER;
            beat_cnt_d = 16'd1;
            ucast_ok_d = (beat_data[15:0] == LOCAL_MAC[47:32]);
            bcast_ok_d = (beat_data[15:0] == 16'hFFFF);
            type_ok_d  = 1'b0;
            err_d      = AVALON_ST_SINK_IN_1.Error;
        end else if (mid_beat) begin
            beat_cnt_d = sat_inc16(beat_cnt_q);
            err_d      = err_q | AVALON_ST_SINK_IN_1.Error;
            case (state_q)
                ST_HEADER: begin
                    if (beat_cnt_q == 16'd1) begin
                        ucast_ok_d = ucast_ok_q & (beat_data == LOCAL_MAC[31:0]);
                        bcast_ok_d = bcast_ok_q & (beat_data == 32'hFFFF_FFFF);
                    end
                    if (beat_cnt_q == HDR_BEATS - 16'd1) begin
                        type_ok_d = (beat_data[15:0] == ETHERTYPE);
                        state_d   = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    speed_sh_d = SPEED_SENSOR_WIDTH'(beat_data[31:16]);
                    adc_sh_d   = ADC_WIDTH'(beat_data[15:0]);
                    state_d    = ST_DRAIN;
                end
                default: begin
                end
            endcase
        end

        if (eop_beat) begin
            state_d = ST_IDLE;
        end
    end

    // The verdict uses the updated flags so a frame can end on the payload beat itself
    assign frame_good = (ucast_ok_d | bcast_ok_d) & type_ok_d & ~err_d
                      & (beat_cnt_d >= MIN_FRAME_BEATS)
                      & ((MTU == 16'd0) | (beat_cnt_d <= MTU));
    assign commit     = frame_end & frame_good;

    // Ready comes up on the first edge after reset release and then stays high
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Parser state, beat counter, match flags and payload shadow registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= 16'd0;
            ucast_ok_q <= 1'b0;
            bcast_ok_q <= 1'b0;
            type_ok_q  <= 1'b0;
            err_q      <= 1'b0;
            speed_sh_q <= '0;
            adc_sh_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            ucast_ok_q <= ucast_ok_d;
            bcast_ok_q <= bcast_ok_d;
            type_ok_q  <= type_ok_d;
            err_q      <= err_d;
            speed_sh_q <= speed_sh_d;
            adc_sh_q   <= adc_sh_d;
        end
    end

    // Publish the shadowed pair with a one-cycle strobe when a frame commits
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            SPEED_SENSOR <= '0;
            ADC          <= '0;
            DATA_VALID   <= 1'b0;
        end else begin
            DATA_VALID <= commit;
            if (commit) begin
                SPEED_SENSOR <= speed_sh_d;
                ADC          <= adc_sh_d;
            end
        end
    end

`ifdef TSE_RX_STATS_EN
    logic drop;

    // A frame is dropped when it is cut short by a new start or ends without passing the checks
    assign drop = (sop_beat & in_frame) | (frame_end & ~frame_good);

    tse_rx_stats_counter #(
        .WIDTH(STATS_WIDTH)
    ) u_frame_count (
        .clock  (CLOCK),
        .reset_n(RESET_N),
        .inc    (commit),
        .count  (RX_FRAME_COUNT)
    );

    tse_rx_stats_counter #(
        .WIDTH(STATS_WIDTH)
    ) u_drop_count (
        .clock  (CLOCK),
        .reset_n(RESET_N),
        .inc    (drop),
        .count  (RX_DROP_COUNT)
    );
`else
    assign RX_FRAME_COUNT = '0;
    assign RX_DROP_COUNT  = '0;
`endif

endmodule

// File: tb/tb_tse_rx_controller.sv
// Self-checking bench for tse_rx_controller. Frames are collected into a queue by a
// frame-level model and judged when they end; every output is compared each cycle.
// Counter expectations follow the TSE_RX_STATS_EN build option.
module tb_tse_rx_controller;
    import AlteraAvalon_Pkg::*;

    localparam logic [47:0] MAC   = 48'h001C_2317_4ACB;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC   = 48'h0200_5E00_0001;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [15:0]            mtu;
    avalon_st_from_source_t sink_in;
    avalon_st_to_source_t   sink_out;
    logic [15:0]            speed;
    logic [15:0]            adc;
    logic                   data_valid;
    logic [31:0]            frame_count;
    logic [31:0]            drop_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [31:0] m_beats[$];
    bit          m_inframe;
    bit          m_err;
    logic        m_ready;
    logic        m_dv;
    logic [15:0] m_speed;
    logic [15:0] m_adc;
    logic [31:0] m_frames;
    logic [31:0] m_drops;

    tse_rx_controller dut (
        .CLOCK               (clock),
        .RESET_N             (reset_n),
        .MTU                 (mtu),
        .AVALON_ST_SINK_IN_1 (sink_in),
        .AVALON_ST_SINK_OUT_1(sink_out),
        .SPEED_SENSOR        (speed),
        .ADC                 (adc),
        .DATA_VALID          (data_valid),
        .RX_FRAME_COUNT      (frame_count),
        .RX_DROP_COUNT       (drop_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef TSE_RX_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_beats.delete();
        m_inframe = 1'b0;
        m_err     = 1'b0;
        m_ready   = 1'b0;
        m_dv      = 1'b0;
        m_speed   = 16'd0;
        m_adc     = 16'd0;
        m_frames  = 32'd0;
        m_drops   = 32'd0;
    endtask

    // Judge a finished frame from its collected beats as a byte-level header check
    task automatic judge_frame();
        int          n;
        bit          ok;
        logic [31:0] b0, b1, b3, b4;
        logic [47:0] dest;
        n  = m_beats.size();
        ok = 1'b0;
        b4 = 32'd0;
        if (n >= 5 && !m_err && (mtu == 16'd0 || n <= int'(mtu))) begin
            b0   = m_beats[0];
            b1   = m_beats[1];
            b3   = m_beats[3];
            b4   = m_beats[4];
            dest = {b0[15:0], b1};
            ok   = ((dest == MAC) || (dest == BCAST)) && (b3[15:0] == ETYPE);
        end
        if (ok) begin
            m_speed  = b4[31:16];
            m_adc    = b4[15:0];
            m_dv     = 1'b1;
            m_frames = sat32(m_frames);
        end else begin
            m_drops = sat32(m_drops);
        end
    endtask

    // Advance the model by one clock edge using the beat currently presented
    task automatic model_step();
        bit acc;
        acc  = sink_in.Valid && m_ready;
        m_dv = 1'b0;
        if (acc) begin
            if (sink_in.StartOfPacket) begin
                if (m_inframe) m_drops = sat32(m_drops);
                m_beats.delete();
                m_beats.push_back(sink_in.Data);
                m_err     = sink_in.Error;
                m_inframe = 1'b1;
            end else if (m_inframe) begin
                m_beats.push_back(sink_in.Data);
                m_err = m_err | sink_in.Error;
            end
            if (sink_in.EndOfPacket && m_inframe) begin
                judge_frame();
                m_inframe = 1'b0;
                m_beats.delete();
            end
        end
        m_ready = 1'b1;
    endtask

    // Present one beat for one clock edge (called 1 time unit after a rising edge)
    task automatic apply_stimulus(input bit v, input bit s, input bit e, input bit er, input logic [31:0] d);
        sink_in.Valid         = v;
        sink_in.StartOfPacket = s;
        sink_in.EndOfPacket   = e;
        sink_in.Error         = er;
        sink_in.Empty         = 2'($urandom_range(0, 3));
        sink_in.Data          = d;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    endtask

    task automatic send_frame(input logic [47:0] dest, input logic [15:0] etype, input logic [31:0] payload,
                              input int len, input int err_beat, input bit close, input bit gaps);
        logic [31:0] d;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) idle();
            end
            case (i)
                0:       d = {16'($urandom), dest[47:32]};
                1:       d = dest[31:0];
                2:       d = SRC[47:16];
                3:       d = {SRC[15:0], etype};
                4:       d = payload;
                default: d = $urandom;
            endcase
            apply_stimulus(1'b1, i == 0, close && (i == len - 1), i == err_beat, d);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sink_in = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check_output("ready_low_after_reset", 32'(sink_out.Ready), 32'd0);
        idle();
        check_output("ready_high_after_reset", 32'(sink_out.Ready), 32'd1);
    endtask

    // Compare every DUT output against the frame-level model on the falling edge
    always @(negedge clock) begin
        if (check_en) begin
            check_output("ready",       32'(sink_out.Ready), 32'(m_ready));
            check_output("data_valid",  32'(data_valid),     32'(m_dv));
            check_output("speed",       32'(speed),          32'(m_speed));
            check_output("adc",         32'(adc),            32'(m_adc));
            check_output("frame_count", frame_count,         stat_exp(m_frames));
            check_output("drop_count",  drop_count,          stat_exp(m_drops));
        end
    end

    initial begin
        logic [47:0] dest;
        logic [15:0] et;
        int          len;
        int          eb;

        sink_in = '0;
        mtu     = 16'd16;
        reset_n = 1'b1;
        #1;
        check_en = 1'b1;
        do_reset();
        check_output("reset_speed", 32'(speed), 32'd0);
        check_output("reset_dv",    32'(data_valid), 32'd0);

        $display("[TB] valid frame to local MAC");
        send_frame(MAC, ETYPE, 32'hDEAD_BEEF, 8, -1, 1'b1, 1'b0);
        check_output("valid_speed", 32'(speed), 32'h0000_DEAD);
        check_output("valid_adc",   32'(adc),   32'h0000_BEEF);
        check_output("valid_dv",    32'(data_valid), 32'd1);
        check_output("valid_frames", frame_count, stat_exp(32'd1));
        idle();
        check_output("valid_dv_one_cycle", 32'(data_valid), 32'd0);

        $display("[TB] wrong EtherType and broadcast destination");
        send_frame(MAC, 16'h0800, 32'h1234_5678, 6, -1, 1'b1, 1'b0);
        check_output("etype_dv",    32'(data_valid), 32'd0);
        check_output("etype_hold",  32'(speed), 32'h0000_DEAD);
        check_output("etype_drops", drop_count, stat_exp(32'd1));
        send_frame(BCAST, ETYPE, 32'h0102_0304, 6, -1, 1'b1, 1'b1);
        check_output("bcast_speed", 32'(speed), 32'h0000_0102);

        $display("[TB] length and MTU limits");
        send_frame(MAC, ETYPE, 32'hAAAA_BBBB, 4, -1, 1'b1, 1'b0);
        check_output("short_dv", 32'(data_valid), 32'd0);
        mtu = 16'd6;
        send_frame(MAC, ETYPE, 32'hCCCC_DDDD, 7, -1, 1'b1, 1'b0);
        check_output("mtu_over_dv", 32'(data_valid), 32'd0);
        send_frame(MAC, ETYPE, 32'h5566_7788, 6, -1, 1'b1, 1'b0);
        check_output("mtu_eq_adc", 32'(adc), 32'h0000_7788);
        mtu = 16'd16;

        $display("[TB] error beat and mid-frame restart");
        send_frame(MAC, ETYPE, 32'h9999_9999, 6, 2, 1'b1, 1'b0);
        check_output("error_dv", 32'(data_valid), 32'd0);
        send_frame(MAC, ETYPE, 32'hEEEE_EEEE, 3, -1, 1'b0, 1'b0);
        send_frame(MAC, ETYPE, 32'hA5A5_5A5A, 5, -1, 1'b1, 1'b0);
        check_output("restart_dv",    32'(data_valid), 32'd1);
        check_output("restart_speed", 32'(speed), 32'h0000_A5A5);

        $display("[TB] back-to-back frames");
        send_frame(MAC, ETYPE, 32'h1111_2222, 5, -1, 1'b1, 1'b0);
        check_output("b2b_first_speed", 32'(speed), 32'h0000_1111);
        send_frame(MAC, ETYPE, 32'h3333_4444, 5, -1, 1'b1, 1'b0);
        check_output("b2b_second_dv",    32'(data_valid), 32'd1);
        check_output("b2b_second_speed", 32'(speed), 32'h0000_3333);
        check_output("b2b_second_adc",   32'(adc),   32'h0000_4444);

        $display("[TB] single-beat frame and stray beats in idle");
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_001C);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        idle();

        $display("[TB] reset in the middle of a frame");
        send_frame(MAC, ETYPE, 32'h6666_6666, 3, -1, 1'b0, 1'b0);
        do_reset();
        check_output("midreset_speed",  32'(speed), 32'd0);
        check_output("midreset_adc",    32'(adc), 32'd0);
        check_output("midreset_frames", frame_count, 32'd0);
        check_output("midreset_drops",  drop_count, 32'd0);
        send_frame(MAC, ETYPE, 32'h7777_8888, 5, -1, 1'b1, 1'b0);
        check_output("postreset_speed", 32'(speed), 32'h0000_7777);

        $display("[TB] randomized traffic");
        for (int f = 0; f < 80; f++) begin
            case ($urandom_range(0, 3))
                0:       dest = BCAST;
                1:       dest = {$urandom, 16'($urandom)};
                default: dest = MAC;
            endcase
            et  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ETYPE;
            len = $urandom_range(1, 10);
            eb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : -1;
            case ($urandom_range(0, 2))
                0:       mtu = 16'd0;
                1:       mtu = 16'd6;
                default: mtu = 16'd16;
            endcase
            send_frame(dest, et, $urandom, len, eb, 1'b1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                apply_stimulus(1'b1, 1'b0, $urandom_range(0, 1) == 1, 1'b0, $urandom);
            end
        end
        repeat (3) idle();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
